// File: rtl/gps_sample_packer_pkg.sv
// rtl/gps_sample_packer_pkg.sv - shared types and default widths for the GPS sample packer
package gps_sample_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_PACK = 2'd2
    } pack_state_t;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/gps_sample_packer_if.sv
// rtl/gps_sample_packer_if.sv - front-end stream and sample-buffer write port bundle
interface gps_sample_packer_if
    import gps_sample_packer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ERR_W  = DEF_ERR_W
);
    logic              gps_rec_clk;
    logic              gps_rec_data;
    logic              gps_rec_sync;
    logic              enable;
    logic              clear;
    logic [WORD_W-1:0] word_o;
    logic [ADDR_W-1:0] word_addr_o;
    logic              word_we_o;
    logic              wrap_o;
    logic              locked_o;
    logic [ERR_W-1:0]  sync_err_o;

    modport master (
        output gps_rec_clk, gps_rec_data, gps_rec_sync, enable, clear,
        input  word_o, word_addr_o, word_we_o, wrap_o, locked_o, sync_err_o
    );

    modport slave (
        input  gps_rec_clk, gps_rec_data, gps_rec_sync, enable, clear,
        output word_o, word_addr_o, word_we_o, wrap_o, locked_o, sync_err_o
    );
endinterface

// File: rtl/gps_sample_packer_sync_edge.sv
// rtl/gps_sample_packer_sync_edge.sv - 2-FF synchronizer and rising-edge strobe for the front-end inputs
module gps_sample_packer_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic rec_clk,
    input  logic rec_data,
    input  logic rec_sync,
    output logic smp,
    output logic smp_data,
    output logic smp_sync
);
    // bit 2 = front-end clock, bit 1 = data, bit 0 = sync
    logic [2:0] meta_q, meta_d;
    logic [2:0] stab_q, stab_d;
    logic       clk_prev_q, clk_prev_d;
    logic       smp_q, smp_d;
    logic       smp_data_q, smp_data_d;
    logic       smp_sync_q, smp_sync_d;

    always_comb begin
        meta_d     = {rec_clk, rec_data, rec_sync};
        stab_d     = meta_q;
        clk_prev_d = stab_q[2];
        // data and sync come from the same stage as the edge so they stay aligned to it
        smp_d      = stab_q[2] & ~clk_prev_q;
        smp_data_d = stab_q[1];
        smp_sync_d = stab_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= '0;
            stab_q     <= '0;
            clk_prev_q <= 1'b0;
            smp_q      <= 1'b0;
            smp_data_q <= 1'b0;
            smp_sync_q <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            stab_q     <= stab_d;
            clk_prev_q <= clk_prev_d;
            smp_q      <= smp_d;
            smp_data_q <= smp_data_d;
            smp_sync_q <= smp_sync_d;
        end
    end

    assign smp      = smp_q;
    assign smp_data = smp_data_q;
    assign smp_sync = smp_sync_q;
endmodule

// File: rtl/gps_sample_packer.sv
// rtl/gps_sample_packer.sv - packs the front-end bit stream into sync-aligned words with buffer addresses
module gps_sample_packer
    import gps_sample_packer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic sys_clk,
    input  logic sys_rst,
    gps_sample_packer_if.slave bus
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic smp, smp_data, smp_sync;

    gps_sample_packer_sync_edge u_sync_edge (
        .clk      (sys_clk),
        .rst_n    (sys_rst),
        .rec_clk  (bus.gps_rec_clk),
        .rec_data (bus.gps_rec_data),
        .rec_sync (bus.gps_rec_sync),
        .smp      (smp),
        .smp_data (smp_data),
        .smp_sync (smp_sync)
    );

    pack_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic              we_q, we_d;
    logic              wrap_q, wrap_d;
    logic              locked_q, locked_d;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] start_word;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        err_d       = err_q;
        word_d      = word_q;
        word_addr_d = word_addr_q;
        we_d        = 1'b0;
        wrap_d      = 1'b0;

        asm_word          = shreg_q;
        asm_word[idx_q]   = smp_data;
        start_word        = '0;
        start_word[0]     = smp_data;

        if (bus.clear) begin
            addr_d  = '0;
            err_d   = '0;
            idx_d   = '0;
            shreg_d = '0;
            state_d = bus.enable ? ST_HUNT : ST_IDLE;
        end else if (!bus.enable) begin
            idx_d   = '0;
            shreg_d = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (smp && smp_sync) begin
                        shreg_d = start_word;
                        idx_d   = IDX_W'(1);
                        state_d = ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (smp) begin
                        if (smp_sync && idx_q != '0) begin
                            // early sync: drop the partial word and realign on this sample
                            if (err_q != '1) err_d = err_q + 1'b1;
                            shreg_d = start_word;
                            idx_d   = IDX_W'(1);
                        end else if (idx_q == IDX_LAST) begin
                            word_d      = asm_word;
                            word_addr_d = addr_q;
                            we_d        = 1'b1;
                            wrap_d      = &addr_q;
                            addr_d      = addr_q + 1'b1;
                            idx_d       = '0;
                            shreg_d     = '0;
                        end else begin
                            shreg_d = asm_word;
                            idx_d   = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d = (state_d == ST_PACK);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            err_q       <= '0;
            word_q      <= '0;
            word_addr_q <= '0;
            we_q        <= 1'b0;
            wrap_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            word_q      <= word_d;
            word_addr_q <= word_addr_d;
            we_q        <= we_d;
            wrap_q      <= wrap_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.word_o      = word_q;
    assign bus.word_addr_o = word_addr_q;
    assign bus.word_we_o   = we_q;
    assign bus.wrap_o      = wrap_q;
    assign bus.locked_o    = locked_q;
    assign bus.sync_err_o  = err_q;
endmodule

// File: tb/tb_gps_sample_packer.sv
// tb/tb_gps_sample_packer.sv - self-checking bench for gps_sample_packer against a bit-queue reference model
module tb_gps_sample_packer;
    localparam int WW = 32;
    localparam int AW = 2;
    localparam int EW = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    gps_sample_packer_if #(.WORD_W(WW), .ADDR_W(AW), .ERR_W(EW)) bus ();

    gps_sample_packer #(.WORD_W(WW), .ADDR_W(AW), .ERR_W(EW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    typedef struct {
        logic [WW-1:0] w;
        logic [AW-1:0] a;
        logic          wr;
    } exp_t;

    exp_t exp_q[$];
    bit   bits_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_writes = 0;
    int   n_wrap = 0;
    bit   prev_we = 0;

    bit   m_en = 0;
    bit   m_locked = 0;
    int   m_addr = 0;
    int   m_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        m_locked = 0;
        m_addr   = 0;
        m_err    = 0;
    endtask

    task automatic model_disable();
        bits_q.delete();
        m_locked = 0;
    endtask

    task automatic model_sample(input bit d, input bit s);
        exp_t e;
        if (!m_en) return;
        if (!m_locked) begin
            if (!s) return;
            m_locked = 1;
            bits_q.delete();
        end else if (s && bits_q.size() != 0) begin
            if (m_err < (1 << EW) - 1) m_err++;
            bits_q.delete();
        end
        bits_q.push_back(d);
        if (bits_q.size() == WW) begin
            e.w = '0;
            for (int i = 0; i < WW; i++) e.w[i] = bits_q[i];
            e.a  = AW'(m_addr);
            e.wr = (m_addr == (1 << AW) - 1);
            exp_q.push_back(e);
            m_addr = (m_addr + 1) % (1 << AW);
            bits_q.delete();
        end
    endtask

    task automatic send_sample(input bit d, input bit s);
        model_sample(d, s);
        bus.gps_rec_data = d;
        bus.gps_rec_sync = s;
        repeat (3) @(posedge sys_clk);
        #1 bus.gps_rec_clk = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1 bus.gps_rec_clk = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        for (int i = 0; i < WW; i++) send_sample(w[i], i == 0);
    endtask

    always @(negedge sys_clk) begin
        if (bus.wrap_o) chk("wrap_without_we", bus.wrap_o, bus.word_we_o);
        if (bus.word_we_o) begin
            exp_t e;
            n_writes++;
            if (bus.wrap_o) n_wrap++;
            chk("we_back_to_back", prev_we, 1'b0);
            chk("write_was_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word_o", bus.word_o, e.w);
                chk("word_addr_o", bus.word_addr_o, e.a);
                chk("wrap_o", bus.wrap_o, e.wr);
            end
        end
        prev_we = bus.word_we_o;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_word"}, bus.word_o, 0);
        chk({tag, "_addr"}, bus.word_addr_o, 0);
        chk({tag, "_we"}, bus.word_we_o, 0);
        chk({tag, "_wrap"}, bus.wrap_o, 0);
        chk({tag, "_locked"}, bus.locked_o, 0);
        chk({tag, "_err"}, bus.sync_err_o, 0);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        model_reset();
        @(posedge sys_clk);
        #1 bus.clear = 1'b0;
    endtask

    initial begin
        int wr0;
        logic [WW-1:0] rw;
        bus.gps_rec_clk  = 1'b0;
        bus.gps_rec_data = 1'b0;
        bus.gps_rec_sync = 1'b0;
        bus.enable       = 1'b0;
        bus.clear        = 1'b0;

        // reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_all_zero("reset");
        #1 sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 bus.enable = 1'b1;
        m_en = 1;

        // 1: clean alternating words
        wr0 = n_writes;
        for (int k = 0; k < 3; k++) send_word(32'hAAAAAAAA);
        chk("t1_writes", n_writes - wr0, 3);
        chk("t1_word", bus.word_o, 32'hAAAAAAAA);
        chk("t1_err", bus.sync_err_o, 0);
        chk("t1_locked", bus.locked_o, 1);

        // 2: early sync at sample 20
        wr0 = n_writes;
        rw = $urandom();
        for (int i = 0; i < 20; i++) send_sample(rw[i], i == 0);
        send_word($urandom());
        chk("t2_writes", n_writes - wr0, 1);
        chk("t2_err", bus.sync_err_o, 1);
        chk("t2_err_model", bus.sync_err_o, m_err);

        // 3: five clean words from address 0, one wrap
        pulse_clear();
        wr0 = n_writes;
        n_wrap = 0;
        for (int k = 0; k < 5; k++) send_word($urandom());
        chk("t3_writes", n_writes - wr0, 5);
        chk("t3_wraps", n_wrap, 1);
        chk("t3_last_addr", bus.word_addr_o, 0);

        // 4: enable dropped mid-word
        wr0 = n_writes;
        rw = $urandom();
        for (int i = 0; i < 10; i++) send_sample(rw[i], i == 0);
        bus.enable = 1'b0;
        m_en = 0;
        model_disable();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t4_locked_off", bus.locked_o, 0);
        for (int i = 0; i < 5; i++) send_sample($urandom_range(0, 1), i == 0);
        chk("t4_locked_still_off", bus.locked_o, 0);
        #1 bus.enable = 1'b1;
        m_en = 1;
        send_word($urandom());
        chk("t4_writes", n_writes - wr0, 1);
        chk("t4_addr", bus.word_addr_o, 1);

        // 5: reset at sample 15
        rw = $urandom();
        for (int i = 0; i < 15; i++) send_sample(rw[i], i == 0);
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        check_all_zero("t5_in_reset");
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        wr0 = n_writes;
        for (int i = 0; i < 7; i++) send_sample($urandom_range(0, 1), 1'b0);
        chk("t5_no_write_before_sync", n_writes - wr0, 0);
        send_word($urandom());
        chk("t5_first_addr", bus.word_addr_o, 0);
        send_word($urandom());

        // 6: saturating error count, then clear
        for (int k = 0; k < 301; k++) begin
            send_sample($urandom_range(0, 1), 1'b1);
            send_sample($urandom_range(0, 1), 1'b0);
        end
        chk("t6_err_sat", bus.sync_err_o, 8'hFF);
        chk("t6_err_model", bus.sync_err_o, m_err);
        pulse_clear();
        @(negedge sys_clk);
        chk("t6_err_cleared", bus.sync_err_o, 0);
        send_word($urandom());
        chk("t6_addr_after_clear", bus.word_addr_o, 0);

        repeat (10) @(posedge sys_clk);
        chk("all_expected_written", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
